// File: rtl/seg7_display_scanner.sv
// seg7_display_scanner: frame-coherent snapshot, BCD split, 6-digit scan, blink.
// Define LEADING_ZERO_BLANK_EN to blank a zero tens digit (digit 5, timer minutes).
module seg7_display_scanner #(
   parameter int SCAN_DIV  = 4,
   parameter int BLINK_DIV = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  view_sel,
   input  logic [7:0]  display_hour,
   input  logic [7:0]  display_min,
   input  logic [7:0]  display_sec,
   input  logic        is_pm,
   input  logic        AM_PM,
   input  logic [7:0]  current_day,
   input  logic [7:0]  current_month,
   input  logic [15:0] current_year,
   input  logic [7:0]  timer_min,
   input  logic [7:0]  timer_sec,
   input  logic        timer_running,
   input  logic        timer_done,
   input  logic        alarm_sound,
   output logic [6:0]  seg,
   output logic [5:0]  an,
   output logic        dp,
   output logic        pm_led
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FW = $clog2(BLINK_DIV + 1);
   localparam logic [1:0] V_CLK  = 2'd0;
   localparam logic [1:0] V_DATE = 2'd1;
   localparam logic [1:0] V_TMR  = 2'd2;

   logic [SW-1:0] r_scan_cnt;
   logic [2:0]    r_digit_idx;
   logic [FW-1:0] r_frame_cnt;
   logic          r_blink_phase;
   logic          r_first;
   logic [1:0]    r_sv;
   logic [7:0]    r_shi;
   logic [7:0]    r_smid;
   logic [7:0]    r_slo;
   logic          r_spm;
   logic [6:0]    r_seg;
   logic [5:0]    r_an;
   logic          r_dp;
   logic          r_pm_led;

   logic       w_scan_wrap;
   logic       w_frame_end;
   logic       w_load;
   logic       w_blink_src;
   logic       w_blink_on;
   logic [7:0] w_yy;
   logic [1:0] w_lv;
   logic [7:0] w_lhi;
   logic [7:0] w_lmid;
   logic [7:0] w_llo;
   logic       w_lpm;
   logic [1:0] w_v;
   logic [7:0] w_hi;
   logic [7:0] w_mid;
   logic [7:0] w_lo;
   logic       w_pm;
   logic [7:0] w_fld;
   logic [3:0] w_tens;
   logic [3:0] w_ones;
   logic [3:0] w_bcd;
   logic       w_dash;
   logic       w_lz;
   logic       w_blank_dig;
   logic [6:0] w_num;
   logic [6:0] w_seg;
   logic [5:0] w_an;
   logic       w_dp;

   assign w_scan_wrap = (r_scan_cnt == SW'(SCAN_DIV - 1));
   assign w_frame_end = w_scan_wrap && (r_digit_idx == 3'd5);
   assign w_load      = r_first | w_frame_end;
   assign w_blink_src = alarm_sound | timer_done;
   assign w_blink_on  = r_blink_phase & w_blink_src;
   assign w_yy        = 8'(current_year % 16'd100);

   always_comb begin
      if (timer_running || view_sel == V_TMR)
         w_lv = V_TMR;
      else if (view_sel == V_DATE)
         w_lv = V_DATE;
      else
         w_lv = V_CLK;
   end

   always_comb begin
      w_lhi  = display_hour;
      w_lmid = display_min;
      w_llo  = display_sec;
      w_lpm  = AM_PM & is_pm;
      unique case (w_lv)
         V_DATE: begin
            w_lhi  = current_day;
            w_lmid = current_month;
            w_llo  = w_yy;
            w_lpm  = 1'b0;
         end
         V_TMR: begin
            w_lhi  = 8'd0;
            w_lmid = timer_min;
            w_llo  = timer_sec;
            w_lpm  = 1'b0;
         end
         default: ;
      endcase
   end

   // First frame after reset shows the values being captured on that edge
   assign w_v   = r_first ? w_lv   : r_sv;
   assign w_hi  = r_first ? w_lhi  : r_shi;
   assign w_mid = r_first ? w_lmid : r_smid;
   assign w_lo  = r_first ? w_llo  : r_slo;
   assign w_pm  = r_first ? w_lpm  : r_spm;

   always_comb begin
      unique case (r_digit_idx)
         3'd5, 3'd4: w_fld = w_hi;
         3'd3, 3'd2: w_fld = w_mid;
         default:    w_fld = w_lo;
      endcase
   end

   assign w_tens = 4'(w_fld / 8'd10);
   assign w_ones = 4'(w_fld % 8'd10);
   assign w_bcd  = r_digit_idx[0] ? w_tens : w_ones;
   assign w_dash = (w_fld > 8'd99);

`ifdef LEADING_ZERO_BLANK_EN
   assign w_lz = !w_dash && (w_tens == 4'd0) &&
                 ((r_digit_idx == 3'd5) ||
                  (w_v == V_TMR && r_digit_idx == 3'd3));
`else
   assign w_lz = 1'b0;
`endif

   assign w_blank_dig = ((w_v == V_TMR) && (r_digit_idx >= 3'd4)) | w_lz;

   always_comb begin
      unique case (w_bcd)
         4'd0:    w_num = 7'b1000000;
         4'd1:    w_num = 7'b1111001;
         4'd2:    w_num = 7'b0100100;
         4'd3:    w_num = 7'b0110000;
         4'd4:    w_num = 7'b0011001;
         4'd5:    w_num = 7'b0010010;
         4'd6:    w_num = 7'b0000010;
         4'd7:    w_num = 7'b1111000;
         4'd8:    w_num = 7'b0000000;
         4'd9:    w_num = 7'b0010000;
         default: w_num = 7'h7F;
      endcase
   end

   always_comb begin
      if (w_blank_dig)
         w_seg = 7'h7F;
      else if (w_dash)
         w_seg = 7'b0111111;
      else
         w_seg = w_num;
   end

   assign w_an = (w_blank_dig || w_blink_on) ? 6'h3F : ~(6'd1 << r_digit_idx);
   assign w_dp = !((r_digit_idx == 3'd2) ||
                   (r_digit_idx == 3'd4 && w_v != V_TMR));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_scan_cnt  <= '0;
         r_digit_idx <= 3'd0;
         r_first     <= 1'b1;
      end else begin
         r_first    <= 1'b0;
         r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
         if (w_scan_wrap)
            r_digit_idx <= (r_digit_idx == 3'd5) ? 3'd0 : r_digit_idx + 3'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sv   <= V_CLK;
         r_shi  <= 8'd0;
         r_smid <= 8'd0;
         r_slo  <= 8'd0;
         r_spm  <= 1'b0;
      end else if (w_load) begin
         r_sv   <= w_lv;
         r_shi  <= w_lhi;
         r_smid <= w_lmid;
         r_slo  <= w_llo;
         r_spm  <= w_lpm;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frame_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else if (!w_blink_src) begin
         r_frame_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else if (w_frame_end) begin
         if (r_frame_cnt == FW'(BLINK_DIV - 1)) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_seg    <= 7'h7F;
         r_an     <= 6'h3F;
         r_dp     <= 1'b1;
         r_pm_led <= 1'b0;
      end else begin
         r_seg    <= w_seg;
         r_an     <= w_an;
         r_dp     <= w_dp;
         r_pm_led <= w_pm;
      end
   end

   assign seg    = r_seg;
   assign an     = r_an;
   assign dp     = r_dp;
   assign pm_led = r_pm_led;

endmodule

// File: tb/tb_seg7_display_scanner.sv
// tb_seg7_display_scanner: frame-level reference model feeds a scoreboard queue;
// a falling-edge monitor pops and compares every displayed cycle.
`timescale 1ns/1ps
module tb_seg7_display_scanner;

   localparam int SCAN_DIV  = 4;
   localparam int BLINK_DIV = 2;
   localparam int FRAME     = 6 * SCAN_DIV;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  view_sel = 2'd0;
   logic [7:0]  display_hour = 8'd0;
   logic [7:0]  display_min = 8'd0;
   logic [7:0]  display_sec = 8'd0;
   logic        is_pm = 1'b0;
   logic        AM_PM = 1'b0;
   logic [7:0]  current_day = 8'd0;
   logic [7:0]  current_month = 8'd0;
   logic [15:0] current_year = 16'd0;
   logic [7:0]  timer_min = 8'd0;
   logic [7:0]  timer_sec = 8'd0;
   logic        timer_running = 1'b0;
   logic        timer_done = 1'b0;
   logic        alarm_sound = 1'b0;
   logic [6:0]  seg;
   logic [5:0]  an;
   logic        dp;
   logic        pm_led;

   seg7_display_scanner #(
      .SCAN_DIV (SCAN_DIV),
      .BLINK_DIV(BLINK_DIV)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .view_sel     (view_sel),
      .display_hour (display_hour),
      .display_min  (display_min),
      .display_sec  (display_sec),
      .is_pm        (is_pm),
      .AM_PM        (AM_PM),
      .current_day  (current_day),
      .current_month(current_month),
      .current_year (current_year),
      .timer_min    (timer_min),
      .timer_sec    (timer_sec),
      .timer_running(timer_running),
      .timer_done   (timer_done),
      .alarm_sound  (alarm_sound),
      .seg          (seg),
      .an           (an),
      .dp           (dp),
      .pm_led       (pm_led)
   );

   typedef struct packed {
      logic [1:0] view;
      logic [7:0] hi;
      logic [7:0] mid;
      logic [7:0] lo;
      logic       pm;
   } snap_t;

   typedef struct packed {
      logic [6:0] seg;
      logic [5:0] an;
      logic       dp;
      logic       pm;
      logic       blink;
   } exp_t;

   exp_t  q[$];
   exp_t  me;
   snap_t sn;
   int    checks = 0;
   int    failures = 0;
   int    pops = 0;
   int    k = 0;
   int    fcnt = 0;
   bit    ph = 1'b0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_of(input int n);
      case (n)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic snap_t capture();
      snap_t s;
      if (timer_running || view_sel == 2'd2) s.view = 2'd2;
      else if (view_sel == 2'd1)             s.view = 2'd1;
      else                                   s.view = 2'd0;
      s.pm = 1'b0;
      case (s.view)
         2'd0: begin
            s.hi = display_hour; s.mid = display_min; s.lo = display_sec;
            s.pm = AM_PM & is_pm;
         end
         2'd1: begin
            s.hi = current_day; s.mid = current_month;
            s.lo = 8'(current_year % 100);
         end
         default: begin
            s.hi = 8'd0; s.mid = timer_min; s.lo = timer_sec;
         end
      endcase
      return s;
   endfunction

   function automatic exp_t predict(input snap_t s, input int d, input bit blink);
      exp_t e;
      int   vals[3];
      int   v;
      int   dig;
      bit   blank;
      vals[0] = s.hi;
      vals[1] = s.mid;
      vals[2] = s.lo;
      v = vals[2 - d / 2];
      dig = (d % 2 == 1) ? v / 10 : v % 10;
      blank = (s.view == 2'd2) && (d >= 4);
`ifdef LEADING_ZERO_BLANK_EN
      if (v <= 99 && v / 10 == 0 && (d == 5 || (s.view == 2'd2 && d == 3)))
         blank = 1'b1;
`endif
      if (blank)       e.seg = 7'h7F;
      else if (v > 99) e.seg = 7'b0111111;
      else             e.seg = seg_of(dig);
      e.an    = (blank || blink) ? 6'h3F : ~6'(1 << d);
      e.dp    = !(d == 2 || (d == 4 && s.view != 2'd2));
      e.pm    = (s.view == 2'd0) && s.pm;
      e.blink = blink;
      return e;
   endfunction

   // Reference: output after edge k shows digit ((k-1)/SCAN_DIV)%6 of frame (k-1)/FRAME
   always @(posedge clk) begin
      if (reset) begin
         k = 0;
         ph = 1'b0;
         fcnt = 0;
         q.delete();
      end else begin
         bit src;
         k++;
         if (k == 1) sn = capture();
         src = alarm_sound | timer_done;
         q.push_back(predict(sn, ((k - 1) / SCAN_DIV) % 6, ph && src));
         if (!src) begin
            ph = 1'b0;
            fcnt = 0;
         end else if (k % FRAME == 0) begin
            fcnt++;
            if (fcnt == BLINK_DIV) begin
               fcnt = 0;
               ph = !ph;
            end
         end
         if (k % FRAME == 0) sn = capture();
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         chk("rst_seg", seg, 7'h7F);
         chk("rst_an", an, 6'h3F);
         chk("rst_dp", dp, 1);
         chk("rst_pm", pm_led, 0);
      end else if (q.size() > 0) begin
         me = q.pop_front();
         pops++;
         chk("an", an, me.an);
         if (!me.blink) begin
            chk("seg", seg, me.seg);
            chk("dp", dp, me.dp);
         end
         chk("pm_led", pm_led, me.pm);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   function automatic logic [7:0] rval();
      if ($urandom_range(0, 7) == 0) return 8'($urandom_range(100, 255));
      return 8'($urandom_range(0, 99));
   endfunction

   initial begin
      bit found;
      step(3);
      chk("reset_an_direct", an, 6'h3F);
      display_hour = 8'd23;
      display_min = 8'd59;
      display_sec = 8'd50;
      reset = 1'b0;
      step(3 * FRAME);
      step(10);
      display_sec = 8'd51;
      step(2 * FRAME);
      timer_running = 1'b1;
      timer_min = 8'd0;
      timer_sec = 8'd10;
      step(2 * FRAME);
      timer_running = 1'b0;
      alarm_sound = 1'b1;
      step(200);
      alarm_sound = 1'b0;
      step(FRAME);
      view_sel = 2'd1;
      current_day = 8'd31;
      current_month = 8'd12;
      current_year = 16'd2025;
      step(2 * FRAME);
      current_day = 8'd123;
      step(2 * FRAME);
      view_sel = 2'd0;
      AM_PM = 1'b1;
      is_pm = 1'b1;
      display_hour = 8'd11;
      step(2 * FRAME);
      found = 1'b0;
      for (int i = 0; i < FRAME && !found; i++) begin
         if ((k / SCAN_DIV) % 6 == 3) found = 1'b1;
         else step(1);
      end
      chk("reach_digit3", int'(found), 1);
      reset = 1'b1;
      #1;
      chk("async_seg", seg, 7'h7F);
      chk("async_an", an, 6'h3F);
      chk("async_dp", dp, 1);
      chk("async_pm", pm_led, 0);
      step(2);
      reset = 1'b0;
      step(2 * FRAME);
      for (int n = 0; n < 40; n++) begin
         view_sel = 2'($urandom_range(0, 3));
         display_hour = rval();
         display_min = rval();
         display_sec = rval();
         is_pm = 1'($urandom_range(0, 1));
         AM_PM = 1'($urandom_range(0, 1));
         current_day = rval();
         current_month = rval();
         current_year = 16'($urandom_range(0, 65535));
         timer_min = rval();
         timer_sec = rval();
         timer_running = ($urandom_range(0, 3) == 0);
         timer_done = ($urandom_range(0, 4) == 0);
         alarm_sound = ($urandom_range(0, 4) == 0);
         step($urandom_range(1, 60));
      end
      alarm_sound = 1'b0;
      timer_done = 1'b0;
      step(FRAME);
      chk("scoreboard_pops", int'(pops >= 500), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
